// File: rtl/uart_cmd_rx_if.sv
// rtl/uart_cmd_rx_if.sv - command bus between UART command receiver and core
interface uart_cmd_rx_if;
  logic [2:0]  cmd;
  logic [31:0] cmd_arg0;
  logic        cmd_valid;
  logic        cmd_ready;

  modport master (output cmd, output cmd_arg0, output cmd_valid, input cmd_ready);
  modport slave  (input cmd, input cmd_arg0, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART 8N1 framed command receiver feeding a one-entry valid/ready slot
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int TIMEOUT_BYTES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  uart_cmd_rx_if.master        cmd_bus,
  output logic                 err_framing,
  output logic                 err_checksum,
  output logic                 err_overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam int TO_CYCLES = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
  localparam int TOW = $clog2(TO_CYCLES);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {P_SYNC, P_CMD, P_ARG, P_CSUM} parse_state_t;

  rx_state_t    rstate;
  parse_state_t pstate;

  logic          rx_meta, rx_sync, rx_prev;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          byte_strobe;
  logic [7:0]    byte_data;
  logic          err_framing_q;

  logic [TOW-1:0] to_cnt;
  logic [7:0]     cmd_byte;
  logic [7:0]     csum;
  logic [31:0]    arg;
  logic [1:0]     idx;
  logic           err_checksum_q, err_overrun_q;
  logic [2:0]     cmd_q;
  logic [31:0]    cmd_arg0_q;
  logic           cmd_valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      rstate        <= R_IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      byte_strobe   <= 1'b0;
      byte_data     <= '0;
      err_framing_q <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      byte_strobe   <= 1'b0;
      err_framing_q <= 1'b0;
      timer         <= timer + TW'(1);
      case (rstate)
        R_IDLE: begin
          timer <= '0;
          if (rx_prev && !rx_sync) rstate <= R_START;
        end
        R_START: begin
          // A high level at mid start bit is treated as a line glitch
          if (timer == HALF_LAST) begin
            timer   <= '0;
            bit_cnt <= '0;
            rstate  <= rx_sync ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rstate <= R_STOP;
          end
        end
        R_STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (rx_sync) begin
              byte_strobe <= 1'b1;
              byte_data   <= shreg;
              rstate      <= R_IDLE;
            end else begin
              err_framing_q <= 1'b1;
              rstate        <= R_WAIT_HIGH;
            end
          end
        end
        R_WAIT_HIGH: begin
          timer <= '0;
          if (rx_sync) rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pstate         <= P_SYNC;
      to_cnt         <= '0;
      cmd_byte       <= '0;
      csum           <= '0;
      arg            <= '0;
      idx            <= '0;
      err_checksum_q <= 1'b0;
      err_overrun_q  <= 1'b0;
      cmd_q          <= '0;
      cmd_arg0_q     <= '0;
      cmd_valid_q    <= 1'b0;
    end else begin
      err_checksum_q <= 1'b0;
      err_overrun_q  <= 1'b0;
      if (cmd_valid_q && cmd_bus.cmd_ready) cmd_valid_q <= 1'b0;

      if (err_framing_q) begin
        pstate <= P_SYNC;
        to_cnt <= '0;
      end else if (byte_strobe) begin
        to_cnt <= '0;
        case (pstate)
          P_SYNC: if (byte_data == 8'hA5) pstate <= P_CMD;
          P_CMD: begin
            cmd_byte <= byte_data;
            csum     <= byte_data;
            idx      <= '0;
            pstate   <= P_ARG;
          end
          P_ARG: begin
            // Little-endian: after four shifts byte 0 lands in arg[7:0]
            arg  <= {byte_data, arg[31:8]};
            csum <= csum ^ byte_data;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) pstate <= P_CSUM;
          end
          P_CSUM: begin
            pstate <= P_SYNC;
            if (byte_data == csum && cmd_byte[7:3] == 5'd0) begin
              if (!cmd_valid_q || cmd_bus.cmd_ready) begin
                cmd_q       <= cmd_byte[2:0];
                cmd_arg0_q  <= arg;
                cmd_valid_q <= 1'b1;
              end else begin
                err_overrun_q <= 1'b1;
              end
            end else begin
              err_checksum_q <= 1'b1;
            end
          end
          default: pstate <= P_SYNC;
        endcase
      end else if (pstate != P_SYNC) begin
        if (to_cnt == TO_LAST) begin
          pstate <= P_SYNC;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TOW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign cmd_bus.cmd       = cmd_q;
  assign cmd_bus.cmd_arg0  = cmd_arg0_q;
  assign cmd_bus.cmd_valid = cmd_valid_q;
  assign err_framing       = err_framing_q;
  assign err_checksum      = err_checksum_q;
  assign err_overrun       = err_overrun_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;
  localparam int CPB = 8;
  localparam int TOB = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic err_framing, err_checksum, err_overrun;

  always #5 clk = ~clk;

  uart_cmd_rx_if bus ();

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BYTES(TOB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .cmd_bus      (bus),
    .err_framing  (err_framing),
    .err_checksum (err_checksum),
    .err_overrun  (err_overrun)
  );

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] arg;
  } exp_t;

  typedef struct {
    logic [55:0] bytes;
    logic        good;
    logic [2:0]  cmd;
    logic [31:0] arg;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];

  int n_vec = 0;
  int n_miss = 0;
  int n_fe = 0, n_ce = 0, n_oe = 0, n_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (err_framing)  n_fe++;
    if (err_checksum) n_ce++;
    if (err_overrun)  n_oe++;
    if (err_framing || err_checksum || err_overrun)
      check("err_onehot", 32'(err_framing) + 32'(err_checksum) + 32'(err_overrun), 1);
    if (bus.cmd_valid && bus.cmd_ready) begin
      n_acc++;
      if (sb.size() == 0) begin
        check("sb_unexpected", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("sb_cmd", 32'(bus.cmd), 32'(e.cmd));
        check("sb_arg", bus.cmd_arg0, e.arg);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input bit ready_at_end);
    rx = 1'b0;
    idle(CPB);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      idle(CPB);
    end
    rx = stop_val;
    if (ready_at_end) begin
      idle(CPB - 1);
      bus.cmd_ready = 1'b1;
      idle(1);
    end else begin
      idle(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [55:0] bytes, input bit ready_last);
    for (int k = 0; k < 7; k++)
      send_byte(bytes[55 - 8*k -: 8], 1'b1, ready_last && (k == 6));
  endtask

  task automatic push_vec(input int i);
    exp_t e;
    e.cmd = vt[i].cmd;
    e.arg = vt[i].arg;
    sb.push_back(e);
  endtask

  initial begin
    int fe0, ce0, oe0, acc0, bad;

    vt[0] = '{56'hA5_02_10_00_00_00_12, 1'b1, 3'd2, 32'h0000_0010};
    vt[1] = '{56'hA5_01_78_56_34_12_09, 1'b1, 3'd1, 32'h1234_5678};
    vt[2] = '{56'hA5_03_00_00_00_00_00, 1'b0, 3'd0, 32'h0};
    vt[3] = '{56'hA5_0B_00_00_00_00_0B, 1'b0, 3'd0, 32'h0};
    vt[4] = '{56'hA5_07_FF_FF_FF_FF_07, 1'b1, 3'd7, 32'hFFFF_FFFF};
    vt[5] = '{56'hA5_04_EF_BE_AD_DE_26, 1'b1, 3'd4, 32'hDEAD_BEEF};
    vt[6] = '{56'hA5_01_78_56_34_12_0D, 1'b0, 3'd0, 32'h0};

    bus.cmd_ready = 1'b0;
    idle(3);
    check("rst_valid", 32'(bus.cmd_valid), 0);
    check("rst_cmd", 32'(bus.cmd), 0);
    check("rst_arg", bus.cmd_arg0, 0);
    check("rst_errs", {29'd0, err_framing, err_checksum, err_overrun}, 0);
    reset = 1'b1;
    idle(5);

    for (int i = 0; i < 7; i++) begin
      bus.cmd_ready = 1'b1;
      ce0 = n_ce;
      acc0 = n_acc;
      if (vt[i].good) push_vec(i);
      send_frame(vt[i].bytes, 1'b0);
      idle(20);
      check("tbl_csum_err", n_ce - ce0, vt[i].good ? 0 : 1);
      check("tbl_accepts", n_acc - acc0, vt[i].good ? 1 : 0);
      check("tbl_sb_empty", sb.size(), 0);
    end

    // held command while core stalls
    bus.cmd_ready = 1'b0;
    push_vec(1);
    send_frame(vt[1].bytes, 1'b0);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!(bus.cmd_valid === 1'b1 && bus.cmd === 3'd1 && bus.cmd_arg0 === 32'h1234_5678)) bad++;
    end
    check("hold_stable", bad, 0);
    @(posedge clk);
    #1 bus.cmd_ready = 1'b1;
    idle(1);
    check("hold_valid_drop", 32'(bus.cmd_valid), 0);
    check("hold_sb_empty", sb.size(), 0);

    // framing error on third byte
    fe0 = n_fe; ce0 = n_ce; acc0 = n_acc;
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    idle(20);
    check("frm_fe", n_fe - fe0, 1);
    check("frm_ce", n_ce - ce0, 0);
    check("frm_acc", n_acc - acc0, 0);

    // short low glitch on idle line
    fe0 = n_fe; ce0 = n_ce; acc0 = n_acc;
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(40);
    check("glitch_errs", (n_fe - fe0) + (n_ce - ce0), 0);
    check("glitch_acc", n_acc - acc0, 0);
    push_vec(0);
    send_frame(vt[0].bytes, 1'b0);
    idle(20);
    check("glitch_next_acc", n_acc - acc0, 1);

    // overrun while slot held
    bus.cmd_ready = 1'b0;
    oe0 = n_oe;
    push_vec(0);
    send_frame(vt[0].bytes, 1'b0);
    send_frame(vt[4].bytes, 1'b0);
    idle(10);
    check("ovr_count", n_oe - oe0, 1);
    check("ovr_held_cmd", 32'(bus.cmd), 2);
    check("ovr_held_arg", bus.cmd_arg0, 32'h0000_0010);
    bus.cmd_ready = 1'b1;
    idle(3);
    check("ovr_sb_empty", sb.size(), 0);

    // acceptance coincides with second frame load
    bus.cmd_ready = 1'b0;
    oe0 = n_oe; acc0 = n_acc;
    push_vec(0);
    push_vec(4);
    send_frame(vt[0].bytes, 1'b0);
    send_frame(vt[4].bytes, 1'b1);
    idle(10);
    check("swap_overrun", n_oe - oe0, 0);
    check("swap_acc", n_acc - acc0, 2);
    check("swap_sb_empty", sb.size(), 0);

    // mid-frame timeout
    bus.cmd_ready = 1'b1;
    ce0 = n_ce; acc0 = n_acc;
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    idle(200);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    idle(20);
    check("tmo_ce", n_ce - ce0, 0);
    check("tmo_acc", n_acc - acc0, 0);

    // reset mid-byte with a held command
    bus.cmd_ready = 1'b0;
    push_vec(5);
    send_frame(vt[5].bytes, 1'b0);
    idle(5);
    check("prerst_valid", 32'(bus.cmd_valid), 1);
    rx = 1'b0;
    idle(20);
    reset = 1'b0;
    idle(2);
    check("midrst_valid", 32'(bus.cmd_valid), 0);
    check("midrst_cmd", 32'(bus.cmd), 0);
    check("midrst_arg", bus.cmd_arg0, 0);
    sb.delete();
    rx = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(20);
    bus.cmd_ready = 1'b1;
    acc0 = n_acc;
    push_vec(1);
    send_frame(vt[1].bytes, 1'b0);
    idle(20);
    check("postrst_acc", n_acc - acc0, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
